// File: rtl/product_collector_pkg.sv
// Shared constants and types for product_collector.
// The multiplier frame is 10 cycles long; its product becomes final at phase 9.
package product_collector_pkg;

    localparam int FRAME_LEN     = 10;
    localparam int CAPTURE_PHASE = 9;
    localparam int PRODUCT_W     = 16;

    typedef logic [3:0] phase_t;

    // Free-running frame advance: 0..9, then back to 0.
    function automatic phase_t next_phase(input phase_t p);
        return (p == phase_t'(CAPTURE_PHASE)) ? phase_t'(0) : p + phase_t'(1);
    endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry first-in first-out buffer with a registered head.
// A push while full is accepted only when a pop happens in the same cycle.
// Reset is asynchronous and active-low.
module sync_fifo2 #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] data_in,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign head    = head_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage and occupancy update; the head register always holds the oldest entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= data_in;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= data_in;
                    end
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q <= data_in;
                    end else begin
                        tail_q <= data_in;
                    end
                    count_q <= count_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/product_collector.sv
// product_collector: follows the multiplier's 10-cycle frame, captures the
// product at phase 9, sums ACC_LEN products per result and queues results in
// a 2-entry FIFO offered on sum_valid/sum_ready.
// Optional feature macro: PRODUCT_COLLECTOR_SAT_EN (saturating addition + sticky sat).
//
// Output handshake: a result is transferred in every cycle where sum_valid and
// sum_ready are both high; while sum_valid is high and sum_ready is low,
// sum_valid and sum_data hold their values.
module product_collector
    import product_collector_pkg::*;
#(
    parameter int ACC_LEN = 4,
    parameter int ACC_W   = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_sync,
    input  logic [PRODUCT_W-1:0] product,
    input  logic                 clear,
    output logic                 sum_valid,
    output logic [ACC_W-1:0]     sum_data,
    input  logic                 sum_ready,
    output logic                 overflow,
    output logic                 sat
);

    localparam int CNT_W = $clog2(ACC_LEN + 1);

    if (ACC_W < PRODUCT_W) begin : g_acc_w_check
        $error("product_collector: ACC_W must be at least 16");
    end
    if (ACC_LEN < 1 || ACC_LEN > 256) begin : g_acc_len_check
        $error("product_collector: ACC_LEN must be in 1..256");
    end

    phase_t           phase_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] sum_next;
    logic             capture;
    logic             last;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop;
    logic             overflow_q;

    // A capture only happens on a frame that reached phase 9; a mid-frame
    // frame_sync restarts the count so the abandoned frame never gets there.
    assign capture  = (phase_q == phase_t'(CAPTURE_PHASE)) && !clear;
    assign last     = (cnt_q == CNT_W'(ACC_LEN - 1));
    assign push     = capture && last;
    assign pop      = sum_valid && sum_ready;
    assign drop     = push && fifo_full && !pop;
    assign sum_wide = {1'b0, acc_q} + (ACC_W + 1)'(product);

`ifdef PRODUCT_COLLECTOR_SAT_EN
    logic sat_q;
    assign sum_next = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    assign sat      = sat_q;

    // Sticky saturation flag: any captured add that exceeded the sum range.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q <= 1'b0;
        end else if (capture && sum_wide[ACC_W]) begin
            sat_q <= 1'b1;
        end
    end
`else
    logic unused_carry;
    assign unused_carry = sum_wide[ACC_W];
    assign sum_next     = sum_wide[ACC_W-1:0];
    assign sat          = 1'b0;
`endif

    // Frame phase: the frame_sync cycle counts as phase 0, so the register
    // moves straight on to phase 1 after it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
        end else if (frame_sync) begin
            phase_q <= phase_t'(1);
        end else begin
            phase_q <= next_phase(phase_q);
        end
    end

    // Partial dot-product: accumulate captures, restart after the last one or on clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (capture) begin
            if (last) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= sum_next;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Sticky overflow: a completed sum found the FIFO full with no pop to make room.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;

    sync_fifo2 #(.W(ACC_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .data_in (sum_next),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (sum_data)
    );

    assign sum_valid = !fifo_empty;

endmodule

// File: tb/tb_product_collector.sv
// Bench for product_collector: three instances (ACC_LEN=1, ACC_LEN=4, and
// ACC_LEN=2 with ACC_W=16) share frame/product/clear stimulus; each has its
// own sum_ready. A queue-based reference model predicts every output.
module tb_product_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_sync;
  logic [15:0] product;
  logic        clear;
  logic [2:0]  rdy;

  logic        v1, o1, s1;
  logic [17:0] d1;
  logic        v4, o4, s4;
  logic [17:0] d4;
  logic        vc, oc, sc;
  logic [15:0] dc;

  int n_tests = 0;
  int n_fail  = 0;

  // clock
  always #5 clk = ~clk;

  product_collector #(.ACC_LEN(1), .ACC_W(18)) u1 (
    .clk(clk), .rst(rst), .frame_sync(frame_sync), .product(product), .clear(clear),
    .sum_valid(v1), .sum_data(d1), .sum_ready(rdy[0]), .overflow(o1), .sat(s1));

  product_collector #(.ACC_LEN(4), .ACC_W(18)) u4 (
    .clk(clk), .rst(rst), .frame_sync(frame_sync), .product(product), .clear(clear),
    .sum_valid(v4), .sum_data(d4), .sum_ready(rdy[1]), .overflow(o4), .sat(s4));

  product_collector #(.ACC_LEN(2), .ACC_W(16)) u16 (
    .clk(clk), .rst(rst), .frame_sync(frame_sync), .product(product), .clear(clear),
    .sum_valid(vc), .sum_data(dc), .sum_ready(rdy[2]), .overflow(oc), .sat(sc));

  // reference model state
  int          len [3] = '{1, 4, 2};
  longint      maxv[3] = '{262143, 262143, 65535};
  longint      part[3];
  int          pcnt[3];
  bit          ov  [3];
  bit          st  [3];
  int          since;
  logic [17:0] exp_q0[$];
  logic [17:0] exp_q1[$];
  logic [17:0] exp_q2[$];

  function automatic int qsz(input int i);
    case (i)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [17:0] qfront(input int i);
    case (i)
      0: return exp_q0[0];
      1: return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  task automatic qpush(input int i, input logic [17:0] v);
    case (i)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  task automatic qpop(input int i);
    case (i)
      0: void'(exp_q0.pop_front());
      1: void'(exp_q1.pop_front());
      default: void'(exp_q2.pop_front());
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model of one clock cycle, computed from the inputs currently driven.
  task automatic model_step();
    bit     cap;
    bit     pop;
    bit     do_push;
    longint t;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        part[i] = 0; pcnt[i] = 0; ov[i] = 0; st[i] = 0;
      end
      exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
      since = 0;
      return;
    end
    // products are final 9 cycles after a frame start; frames repeat every 10
    cap = ((since % 10) == 9) && !clear;
    for (int i = 0; i < 3; i++) begin
      pop     = (qsz(i) > 0) && rdy[i];
      do_push = 0;
      t       = 0;
      if (clear) begin
        part[i] = 0;
        pcnt[i] = 0;
      end else if (cap) begin
        t = part[i] + longint'(product);
        if (t > maxv[i]) begin
`ifdef PRODUCT_COLLECTOR_SAT_EN
          t     = maxv[i];
          st[i] = 1;
`else
          t = t % (maxv[i] + 1);
`endif
        end
        pcnt[i]++;
        if (pcnt[i] == len[i]) begin
          do_push = 1;
          part[i] = 0;
          pcnt[i] = 0;
        end else begin
          part[i] = t;
        end
      end
      if (pop) qpop(i);
      if (do_push) begin
        if (qsz(i) < 2) qpush(i, t[17:0]);
        else ov[i] = 1;
      end
    end
    since = frame_sync ? 1 : since + 1;
  endtask

  task automatic check_all(input string tag);
    logic        v, o, s;
    logic [17:0] d;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin v = v1; d = d1; o = o1; s = s1; end
        1: begin v = v4; d = d4; o = o4; s = s4; end
        default: begin v = vc; d = {2'b00, dc}; o = oc; s = sc; end
      endcase
      chk($sformatf("%s_u%0d_valid", tag, i), {31'd0, v}, {31'd0, qsz(i) > 0});
      if (qsz(i) > 0) chk($sformatf("%s_u%0d_data", tag, i), {14'd0, d}, {14'd0, qfront(i)});
      chk($sformatf("%s_u%0d_ovf", tag, i), {31'd0, o}, {31'd0, ov[i]});
      chk($sformatf("%s_u%0d_sat", tag, i), {31'd0, s}, {31'd0, st[i]});
    end
  endtask

  // driver: one cycle with the inputs already set, then check at the falling edge
  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drive(input logic fs, input logic clr);
    frame_sync = fs;
    clear      = clr;
    product    = 16'($urandom_range(0, 65535));
  endtask

  // one full frame: pulse, eight filler cycles, then the final product at phase 9
  task automatic frame(input logic [15:0] p, input string tag);
    drive(1'b1, 1'b0);
    cyc(tag);
    repeat (8) begin
      drive(1'b0, 1'b0);
      cyc(tag);
    end
    drive(1'b0, 1'b0);
    product = p;
    cyc(tag);
  endtask

  initial begin
    rst        = 1'b1;
    frame_sync = 1'b0;
    clear      = 1'b0;
    product    = 16'd0;
    rdy        = 3'b111;
    #1 rst = 1'b0;
    @(negedge clk);

    // reset state
    cyc("rst");
    cyc("rst");
    chk("rst_data_u1", {14'd0, d1}, 32'd0);
    chk("rst_data_u4", {14'd0, d4}, 32'd0);
    chk("rst_data_u16", {16'd0, dc}, 32'd0);
    rst = 1'b1;

    // single results, saturation/wrap pair, then clear after 2 of 4 products
    frame(16'd65025, "single");
    frame(16'd1000, "satwrap");
    drive(1'b0, 1'b1);
    cyc("clear");
    frame(16'd3, "dot");
    frame(16'd10, "dot");
    frame(16'd200, "dot");
    frame(16'd65025, "dot");
    drive(1'b0, 1'b0);
    cyc("dot_tail");
    cyc("dot_tail");

    // backpressure on the ACC_LEN=1 instance: two held, third dropped
    rdy = 3'b110;
    for (int k = 0; k < 3; k++) frame(16'($urandom_range(0, 65535)), "bp");
    drive(1'b0, 1'b0);
    cyc("bp_hold");
    rdy = 3'b111;
    repeat (3) begin
      drive(1'b0, 1'b0);
      cyc("bp_drain");
    end

    // resync: pulse at phase 5 abandons the frame
    drive(1'b1, 1'b0);
    cyc("resync");
    repeat (4) begin
      drive(1'b0, 1'b0);
      cyc("resync");
    end
    drive(1'b1, 1'b0);
    cyc("resync");
    repeat (12) begin
      drive(1'b0, 1'b0);
      cyc("resync");
    end

    // randomized traffic
    repeat (400) begin
      drive(($urandom_range(0, 14) == 0), ($urandom_range(0, 24) == 0));
      rdy = 3'($urandom_range(0, 7));
      cyc("rand");
    end

    // async reset mid-frame with one entry held
    rdy = 3'b000;
    frame(16'($urandom_range(0, 65535)), "pre_rst");
    repeat (3) begin
      drive(1'b0, 1'b0);
      cyc("pre_rst");
    end
    #2 rst = 1'b0;
    #1;
    chk("async_rst_u1_valid", {31'd0, v1}, 32'd0);
    chk("async_rst_u4_valid", {31'd0, v4}, 32'd0);
    chk("async_rst_u16_valid", {31'd0, vc}, 32'd0);
    chk("async_rst_u1_ovf", {31'd0, o1}, 32'd0);
    cyc("in_rst");
    rst = 1'b1;
    rdy = 3'b111;
    frame(16'($urandom_range(0, 65535)), "post_rst");
    frame(16'($urandom_range(0, 65535)), "post_rst");
    drive(1'b0, 1'b0);
    cyc("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/product_collector.md
# product_collector

Downstream consumer of the sequential 8x8 shift-add multiplier. It tracks the multiplier's 10-cycle frame, captures each 16-bit product in the cycle it becomes final, and sums `ACC_LEN` consecutive products into one dot-product result. Results are buffered in a 2-entry FIFO and offered on a valid/ready output. It sits between the multiplier and any accumulate/readout logic.

## Interface
Parameters:
- `ACC_LEN`, 4: products summed per result; legal range 1..256.
- `ACC_W`, 18: sum width; must be at least 16. Elaboration error if smaller.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-low: asserted at 0, released synchronously to `clk` by the top level.
- `frame_sync`  in  1  one-cycle pulse in the cycle the multiplier's stage is 0, i.e. the cycle its operands are sampled.
- `product`  in  16  multiplier `out`.
- `clear`  in  1  synchronous abort of the partial sum.
- `sum_valid`  out  1  FIFO head valid.
- `sum_data`  out  ACC_W  FIFO head value.
- `sum_ready`  in  1  consumer accepts the head.
- `overflow`  out  1  sticky; a completed sum was dropped because the FIFO was full.
- `sat`  out  1  sticky; only when saturation is enabled (see Configuration).

## Operation
- **Frame counter `phase` (0..9):**
  - Reset value 0 (`rst` must also hold the multiplier in reset).
  - Increments each cycle and wraps 9→0.
  - `frame_sync` forces phase 0 that cycle, whatever its current value.
  - If `frame_sync` arrives when phase is not 9, the current frame is abandoned and no product is captured from it.
- **Capture:**
  - At phase 9, `product` holds the full product of the operands sampled 9 cycles earlier. The block adds it to `acc` and increments `cnt`.
  - Addition is modulo 2^ACC_W, or saturating (see Configuration).
- **Completion:** when a capture brings `cnt` to `ACC_LEN`:
  - The updated sum is pushed into the FIFO.
  - `acc` and `cnt` are set to 0 in the same cycle.
- **`clear`:**
  - Sets `acc` and `cnt` to 0 and suppresses any capture or push in that cycle.
  - Does not affect the FIFO, `phase`, or the sticky flags.
- **FIFO (2 entries, first in first out):**
  - A pop occurs when `sum_valid && sum_ready`.
  - A push when full: if a pop happens in the same cycle, the push is accepted. Otherwise the sum is dropped and `overflow` sets.
  - A simultaneous push and pop when empty is not possible, because `sum_valid` is low when empty.
- **Sticky flags:** `overflow` and `sat` clear only on reset.
- **Reset values:**
  - `sum_valid` = 0, `sum_data` = 0, `overflow` = 0, `sat` = 0.
  - Internal state: `phase` = 0, `acc` = 0, `cnt` = 0, FIFO empty.
  - Asserting reset mid-frame discards the partial sum and all FIFO contents immediately.

## Timing
- `frame_sync` in cycle t → capture in cycle t+9 → frame restarts at phase 0 in cycle t+10 without a further pulse.
- Push in cycle c → `sum_valid` = 1 in cycle c+1, with `sum_data` registered.
- Pop in cycle c → the next head is visible in cycle c+1, or `sum_valid` = 0 if the FIFO is now empty.
- Sustained throughput is one result per 10·ACC_LEN cycles. With `sum_ready` held low, 2 results are held and the 3rd is dropped.
- Holding `sum_valid` stable: once asserted, `sum_valid` and `sum_data` stay unchanged until popped.

## Configuration
- `PRODUCT_COLLECTOR_SAT_EN` defined:
  - Addition saturates at 2^ACC_W−1.
  - `sat` sets on any saturating add.
- Not defined:
  - Addition wraps modulo 2^ACC_W.
  - `sat` is tied to 0.

## Structure
- Package `product_collector_pkg`:
  - `FRAME_LEN` = 10, `CAPTURE_PHASE` = 9, `PRODUCT_W` = 16.
  - typedef `phase_t` (4-bit).
- Sub-module `sync_fifo2`:
  - 2-entry FIFO with parameterised width.
  - Ports: push/data_in, pop, full, empty, head.
  - Asynchronous active-low reset.

## Test plan
- **Single result:** ACC_LEN=1, pulse `frame_sync`, drive `product` = 255·255 = 65025 at phase 9 → `sum_valid` next cycle with `sum_data` = 65025.
- **Dot product:** ACC_LEN=4, four frames with products 3, 10, 200, 65025 → `sum_data` = 65238; no `sum_valid` earlier.
- **Backpressure:** ACC_LEN=1, `sum_ready` = 0 for 3 frames → first 2 sums held in order, 3rd dropped, `overflow` = 1. Then raise `sum_ready` → 2 pops in 2 cycles.
- **Resync:** `frame_sync` at phase 5 → no capture at the old phase 9; the next capture comes 9 cycles after the pulse.
- **Saturation:** ACC_W=16, with the macro defined, products 65025 + 1000 → 65535 and `sat` = 1. Without the macro → 489 (wrapped), `sat` = 0.
- **Reset and clear:** `clear` after 2 of 4 products → next result equals only the later 4 products. `rst` = 0 mid-frame with the FIFO holding 1 entry → `sum_valid` = 0 immediately.
